// File: rtl/aim_fire_if.sv
// Command handshake between a host sequencer and the aim/fire controller.
// One command moves per cycle where cmd_valid and cmd_ready are both high.
interface aim_fire_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_steps;
    logic       cmd_fire;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_fire,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_fire,
        output cmd_ready
    );
endinterface

// File: rtl/aim_fire_ctrl.sv
// Aim-and-fire sequencer: rotates the turret for a timed number of steps,
// settles, holds the servo start for one shot window, then cools down.
module aim_fire_ctrl #(
    parameter int unsigned STEP_CYCLES     = 1000000,
    parameter int unsigned SETTLE_CYCLES   = 5000000,
    parameter int unsigned FIRE_CYCLES     = 100000000,
    parameter int unsigned COOLDOWN_CYCLES = 20000000
) (
    input  logic             clk,
    input  logic             rst_n,
    aim_fire_if.slave        cmd,
    input  logic             abort,
    output logic             turn,
    output logic             turn_back,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    localparam int unsigned MAX_A   = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_B   = (FIRE_CYCLES > COOLDOWN_CYCLES) ? FIRE_CYCLES : COOLDOWN_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] FIRE_LAST   = CW'(FIRE_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ROTATE   = 3'd1,
        S_SETTLE   = 3'd2,
        S_FIRE     = 3'd3,
        S_COOLDOWN = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [7:0]      step_q, step_d;
    logic [7:0]      steps_q, steps_d;
    logic            dir_q, dir_d;
    logic            fire_q, fire_d;
    logic            turn_q, turn_d;
    logic            turn_back_q, turn_back_d;
    logic            start_q, start_d;
    logic            done_q, done_d;
    logic            accept;

    assign cmd.cmd_ready = (state_q == S_IDLE) && !abort;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // NOTE: every signal gets its hold value before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        step_d      = step_q;
        steps_d     = steps_q;
        dir_d       = dir_q;
        fire_d      = fire_q;
        turn_d      = turn_q;
        turn_back_d = turn_back_q;
        start_d     = start_q;
        done_d      = 1'b0;

        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            cyc_d       = '0;
            step_d      = '0;
            turn_d      = 1'b0;
            turn_back_d = 1'b0;
            start_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        dir_d   = cmd.cmd_dir;
                        steps_d = cmd.cmd_steps;
                        fire_d  = cmd.cmd_fire;
                        cyc_d   = '0;
                        step_d  = '0;
                        if (cmd.cmd_steps != 8'd0) begin
                            state_d     = S_ROTATE;
                            turn_d      = !cmd.cmd_dir;
                            turn_back_d = cmd.cmd_dir;
                        end else if (cmd.cmd_fire) begin
                            state_d = S_SETTLE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_ROTATE: begin
                    if (cyc_q == STEP_LAST) begin
                        cyc_d = '0;
                        if (step_q + 8'd1 == steps_q) begin
                            // Final step: drop the drive on the same edge the state leaves ROTATE.
                            step_d      = '0;
                            turn_d      = 1'b0;
                            turn_back_d = 1'b0;
                            if (fire_q) begin
                                state_d = S_SETTLE;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            step_d = step_q + 8'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cyc_q == SETTLE_LAST) begin
                        cyc_d   = '0;
                        state_d = S_FIRE;
                        start_d = 1'b1;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_FIRE: begin
                    if (cyc_q == FIRE_LAST) begin
                        cyc_d   = '0;
                        state_d = S_COOLDOWN;
                        start_d = 1'b0;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_COOLDOWN: begin
                    if (cyc_q == COOL_LAST) begin
                        cyc_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cyc_d       = '0;
                    step_d      = '0;
                    turn_d      = 1'b0;
                    turn_back_d = 1'b0;
                    start_d     = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            step_q      <= '0;
            steps_q     <= '0;
            dir_q       <= 1'b0;
            fire_q      <= 1'b0;
            turn_q      <= 1'b0;
            turn_back_q <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            step_q      <= step_d;
            steps_q     <= steps_d;
            dir_q       <= dir_d;
            fire_q      <= fire_d;
            turn_q      <= turn_d;
            turn_back_q <= turn_back_d;
            start_q     <= start_d;
            done_q      <= done_d;
        end
    end

    assign turn      = turn_q;
    assign turn_back = turn_back_q;
    assign start     = start_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_aim_fire_ctrl.sv
// Bench for aim_fire_ctrl: directed and randomized commands compared cycle by
// cycle against a timeline model built from step/settle/fire/cooldown lengths.
module tb_aim_fire_ctrl;

    localparam int STEP   = 4;
    localparam int SETTLE = 3;
    localparam int FIRE   = 5;
    localparam int COOL   = 2;

    typedef struct packed {
        logic       turn;
        logic       turn_back;
        logic       start;
        logic       busy;
        logic       done;
        logic [2:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       turn, turn_back, start, busy, done;
    logic [2:0] state_dbg;

    aim_fire_if cmd_if ();

    aim_fire_ctrl #(
        .STEP_CYCLES     (STEP),
        .SETTLE_CYCLES   (SETTLE),
        .FIRE_CYCLES     (FIRE),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .abort     (abort),
        .turn      (turn),
        .turn_back (turn_back),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   turn_cnt, tb_cnt, start_cnt, done_cnt, busy_cnt;
    exp_t q[$];
    exp_t cur = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic t, input logic b, input logic s,
                                input logic bz, input logic d, input logic [2:0] st);
        exp_t e;
        e.turn = t; e.turn_back = b; e.start = s; e.busy = bz; e.done = d; e.st = st;
        return e;
    endfunction

    // Expected timeline of one command, one entry per cycle after the accept edge.
    task automatic plan(input logic dir, input logic [7:0] steps, input logic fire);
        for (int i = 0; i < int'(steps) * STEP; i++) q.push_back(mk(!dir, dir, 1'b0, 1'b1, 1'b0, 3'd1));
        if (fire) begin
            for (int i = 0; i < SETTLE; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2));
            for (int i = 0; i < FIRE; i++)   q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3));
            for (int i = 0; i < COOL; i++)   q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
    endtask

    task automatic clr_cnt();
        turn_cnt = 0; tb_cnt = 0; start_cnt = 0; done_cnt = 0; busy_cnt = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("cmd_ready", cmd_if.cmd_ready, (cur.st == 3'd0) && !abort);
        @(posedge clk);
        if (abort && cur.st != 3'd0) begin
            q.delete();
            cur = '0;
        end else begin
            if (cur.st == 3'd0 && !abort && cmd_if.cmd_valid) begin
                accepts++;
                q.delete();
                plan(cmd_if.cmd_dir, cmd_if.cmd_steps, cmd_if.cmd_fire);
            end
            cur = (q.size() > 0) ? q.pop_front() : '0;
        end
        #1;
        chk("turn", turn, cur.turn);
        chk("turn_back", turn_back, cur.turn_back);
        chk("start", start, cur.start);
        chk("busy", busy, cur.busy);
        chk("done", done, cur.done);
        chk("state_dbg", state_dbg, cur.st);
        chk("turn_exclusive", turn & turn_back, 0);
        turn_cnt  += int'(turn);
        tb_cnt    += int'(turn_back);
        start_cnt += int'(start);
        done_cnt  += int'(done);
        busy_cnt  += int'(busy);
    endtask

    task automatic issue(input logic dir, input logic [7:0] steps, input logic fire);
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_steps = steps;
        cmd_if.cmd_fire  = fire;
        cmd_if.cmd_valid = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((cur.st != 3'd0 || q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", (cur.st != 3'd0 || q.size() != 0), 0);
    endtask

    initial begin
        int k;
        int fc;
        int base;

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = 8'd0;
        cmd_if.cmd_fire  = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_if.cmd_ready, 1);
        chk("rst_turn", turn, 0);
        chk("rst_turn_back", turn_back, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Turn 3 steps then fire.
        clr_cnt();
        issue(1'b0, 8'd3, 1'b1);
        run_idle(100);
        chk("t1_turn_cycles", turn_cnt, 3 * STEP);
        chk("t1_turn_back_cycles", tb_cnt, 0);
        chk("t1_start_cycles", start_cnt, FIRE);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_ready_back", cmd_if.cmd_ready, 1);

        // Turn back 2 steps, no fire.
        clr_cnt();
        issue(1'b1, 8'd2, 1'b0);
        run_idle(100);
        chk("t2_turn_back_cycles", tb_cnt, 2 * STEP);
        chk("t2_turn_cycles", turn_cnt, 0);
        chk("t2_start_cycles", start_cnt, 0);
        chk("t2_done_pulses", done_cnt, 1);

        // Fire without rotation, then a null command.
        clr_cnt();
        issue(1'b0, 8'd0, 1'b1);
        k = 0;
        while (!start && k < 20) begin
            tick();
            k++;
        end
        chk("t3_start_delay", k, SETTLE);
        run_idle(100);
        chk("t3_start_cycles", start_cnt, FIRE);
        chk("t3_rot_cycles", turn_cnt + tb_cnt, 0);
        clr_cnt();
        issue(1'b0, 8'd0, 1'b0);
        chk("t3_null_done", done, 1);
        tick();
        chk("t3_null_busy", busy_cnt, 0);

        // cmd_valid held across an operation with changing fields.
        base = accepts;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = 8'd2;
        cmd_if.cmd_fire  = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        k = 0;
        while (accepts < base + 2 && k < 300) begin
            tick();
            cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
            cmd_if.cmd_steps = 8'($urandom_range(0, 3));
            cmd_if.cmd_fire  = 1'($urandom_range(0, 1));
            k++;
        end
        cmd_if.cmd_valid = 1'b0;
        chk("t4_two_accepts", accepts - base, 2);
        run_idle(200);

        // Abort on the third FIRE cycle.
        issue(1'b0, 8'd1, 1'b1);
        fc = 0;
        k = 0;
        while (fc < 3 && k < 100) begin
            tick();
            k++;
            if (cur.st == 3'd3) fc++;
        end
        chk("t5_reached_fire", fc, 3);
        clr_cnt();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_start_dropped", start, 0);
        chk("t5_state_idle", state_dbg, 0);
        repeat (3) tick();
        chk("t5_no_done", done_cnt, 0);
        abort = 1'b1;
        issue(1'b1, 8'd2, 1'b1);
        chk("t5_abort_blocks_accept", busy, 0);
        abort = 1'b0;
        tick();

        // Asynchronous reset in the middle of ROTATE.
        issue(1'b0, 8'd3, 1'b0);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        q.delete();
        cur = '0;
        #1;
        chk("t6_turn_async", turn, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_state_async", state_dbg, 0);
        chk("t6_ready_async", cmd_if.cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt();
        issue(1'b1, 8'd1, 1'b1);
        run_idle(100);
        chk("t6_rerun_turn_back", tb_cnt, STEP);
        chk("t6_rerun_done", done_cnt, 1);

        // Randomized commands with occasional aborts.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            k = 0;
            while ((cur.st != 3'd0 || q.size() != 0) && k < 200) begin
                abort = ($urandom_range(0, 15) == 0);
                tick();
                abort = 1'b0;
                k++;
            end
            chk("rand_idle_timeout", (cur.st != 3'd0 || q.size() != 0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aim_fire_ctrl.md
Name: aim_fire_ctrl

Overview:
Command sequencer directly upstream of the turret/shooter top level. Accepts one aim-and-fire command per valid/ready handshake. Drives the level-sensitive turn / turn_back rotation controls for a timed number of steps, waits for the turret to settle, then holds the servo start control for a fixed shot window. Its outputs connect straight to the turret's turn_pb, turn_back_pb and start inputs. The turret debounces the two rotation inputs, so every rotation drive is held for at least one full step.

Parameters:
STEP_CYCLES, 1000000, clk cycles per rotation step (10 ms at 100 MHz); must be at least the turret debounce window.
SETTLE_CYCLES, 5000000, clk cycles idle between end of rotation and start of the shot.
FIRE_CYCLES, 100000000, clk cycles start is held high (one full SG90 shot cycle).
COOLDOWN_CYCLES, 20000000, clk cycles all drives are low after a shot, before the next command is accepted.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_dir  input  1  0 = turn, 1 = turn_back
cmd_steps  input  8  rotation length in steps (0 = no rotation)
cmd_fire  input  1  1 = fire after rotation; 0 = rotate only
abort  input  1  synchronous abort, level
turn  output  1  to turret turn_pb
turn_back  output  1  to turret turn_back_pb
start  output  1  to turret start
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on normal completion
state_dbg  output  3  current state encoding, for testing

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all counters 0. Outputs: cmd_ready=1, turn=0, turn_back=0, start=0, busy=0, done=0.
- States and state_dbg encodings: IDLE=0, ROTATE=1, SETTLE=2, FIRE=3, COOLDOWN=4. Encodings 5-7 are illegal and recover to IDLE on the next clk.
- Handshake:
  - Accept occurs only when cmd_valid & cmd_ready at a rising clk edge.
  - At accept, cmd_dir, cmd_steps and cmd_fire are latched. Later input changes are ignored.
  - cmd_ready = (state==IDLE) & ~abort.
  - cmd_valid while busy is not queued and is dropped.
- Accept transitions, taken at the accept edge:
  - cmd_steps != 0: go to ROTATE.
  - cmd_steps == 0 and cmd_fire=1: go to SETTLE.
  - cmd_steps == 0 and cmd_fire=0: stay in IDLE and pulse done the next cycle.
- ROTATE:
  - Outputs are registered. Drive goes high on the first cycle in ROTATE: turn = ~dir, turn_back = dir.
  - Duration is exactly cmd_steps*STEP_CYCLES cycles. A cycle counter wraps at STEP_CYCLES-1 and increments the step counter.
  - When the step counter reaches cmd_steps, the drive drops and the state moves to SETTLE if fire=1, else to IDLE with done.
- Invariant: turn and turn_back are never high in the same cycle.
- SETTLE: all drives low for SETTLE_CYCLES, then FIRE.
- FIRE: start=1 for exactly FIRE_CYCLES cycles, then COOLDOWN.
- COOLDOWN: all drives low for COOLDOWN_CYCLES, then IDLE. done pulses on the first IDLE cycle.
- Counter widths: $clog2 of the largest cycle parameter. The step counter is 8 bits. No overflow is possible, because terminal counts are compared with ==.
- abort:
  - Sampled every clk.
  - In any non-IDLE state: the next state is IDLE, turn, turn_back and start go to 0 on that edge, counters clear, and done is not pulsed.
  - Abort during FIRE truncates start.
  - abort together with cmd_valid in IDLE: the command is not accepted.
- Latency from accept to first drive high: 1 cycle (drive is registered at the accept edge).
- busy: high from the accept edge until the return to IDLE.
- Reset mid-operation: immediate return to the reset values without waiting for clk.

Test Plan (bench parameters STEP=4, SETTLE=3, FIRE=5, COOLDOWN=2):
- Reset, then cmd dir=0 steps=3 fire=1 -> turn high for 12 cycles, turn_back stays 0, then 3 low cycles, start high for 5 cycles, 2 low cycles, done pulses once, cmd_ready returns to 1.
- cmd dir=1 steps=2 fire=0 -> turn_back high for 8 cycles, turn stays 0, no start, done pulses right after the drive drops.
- cmd steps=0 fire=1 -> no rotation drive, start is high 3 cycles after accept for 5 cycles; cmd steps=0 fire=0 -> done the next cycle, busy never set.
- cmd_valid held high during a whole operation with different fields -> second command accepted only once cmd_ready=1; latched dir/steps unaffected by mid-operation input changes.
- abort asserted on the 3rd FIRE cycle -> start low from the next edge, state_dbg=0, no done pulse; abort together with cmd_valid in IDLE -> no accept.
- rst_n pulsed low mid-ROTATE between clk edges -> turn drops immediately, all outputs at reset values, the next command runs normally.
